// File: rtl/activation_pkg.sv
// ---------------------------------------------------------------------------
// activation_pkg
// Shared definitions for the piecewise-linear activation unit.
//   - act_mode_e : function select carried with every sample
//   - seg_e      : segment index chosen in stage 1, SEG_SAT marks saturation
//   - c_*()      : breakpoint / intercept constants in Q(fract) format,
//                  built by shifting small integers so they stay exact for
//                  any fract >= 5
// ---------------------------------------------------------------------------
package activation_pkg;

    typedef enum logic [1:0] {
        MODE_HTANH = 2'b00,
        MODE_TANH  = 2'b01,
        MODE_SIGM  = 2'b10,
        MODE_RELU  = 2'b11
    } act_mode_e;

    typedef enum logic [1:0] {
        SEG_0   = 2'd0,
        SEG_1   = 2'd1,
        SEG_2   = 2'd2,
        SEG_SAT = 2'd3
    } seg_e;

    // num * 2^-(den_log2) expressed in Q(fract)
    function automatic int unsigned q_const(input int unsigned num,
                                            input int unsigned den_log2,
                                            input int unsigned fract);
        return num << (fract - den_log2);
    endfunction

    function automatic int unsigned c_one(input int unsigned f);      return q_const(1, 0, f);  endfunction
    function automatic int unsigned c_two(input int unsigned f);      return q_const(2, 0, f);  endfunction
    function automatic int unsigned c_five(input int unsigned f);     return q_const(5, 0, f);  endfunction
    function automatic int unsigned c_half(input int unsigned f);     return q_const(1, 1, f);  endfunction
    function automatic int unsigned c_0p375(input int unsigned f);    return q_const(3, 3, f);  endfunction
    function automatic int unsigned c_0p625(input int unsigned f);    return q_const(5, 3, f);  endfunction
    function automatic int unsigned c_2p375(input int unsigned f);    return q_const(19, 3, f); endfunction
    function automatic int unsigned c_0p15625(input int unsigned f);  return q_const(5, 5, f);  endfunction
    function automatic int unsigned c_0p84375(input int unsigned f);  return q_const(27, 5, f); endfunction

endpackage

// File: rtl/pwl_segment_eval.sv
// ---------------------------------------------------------------------------
// pwl_segment_eval
// Combinational slope term of the piecewise-linear curves: shift-add of the
// non-negative magnitude according to mode and segment. Intercepts are added
// downstream.
//   mode  : function select
//   seg   : segment chosen from the magnitude
//   mag   : |X|, never negative
//   slope : truncated shift-add result
// ---------------------------------------------------------------------------
module pwl_segment_eval
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  act_mode_e             mode,
    input  seg_e                  seg,
    input  logic [DATA_WIDTH-1:0] mag,
    output logic [DATA_WIDTH-1:0] slope
);

    always_comb begin
        slope = '0;
        case (mode)
            MODE_HTANH: slope = (seg == SEG_SAT) ? '0 : mag;
            MODE_TANH: begin
                case (seg)
                    SEG_0:   slope = mag;
                    SEG_1:   slope = (mag >> 1) + (mag >> 4) + (mag >> 5);
                    SEG_2:   slope = mag >> 2;
                    default: slope = '0;
                endcase
            end
            MODE_SIGM: begin
                case (seg)
                    SEG_0:   slope = mag >> 2;
                    SEG_1:   slope = mag >> 3;
                    SEG_2:   slope = mag >> 5;
                    default: slope = '0;
                endcase
            end
            default: slope = mag;
        endcase
    end

endmodule

// File: rtl/activation_pwl_unit.sv
// ---------------------------------------------------------------------------
// activation_pwl_unit
// Three-stage streaming activation unit (hard-tanh, tanh PWL, sigmoid PWL,
// ReLU) on signed Q(FRACT_WIDTH) samples with valid/ready handshakes.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake; in_data = X, in_mode = function
//   out_valid/out_ready   : output handshake; out_data = Y
//   out_sat               : result came from a saturated segment
//   sat_cnt / sat_clr     : count of saturated output transfers, sync clear
// Stage 1 picks magnitude, sign and segment; stage 2 forms the slope term;
// stage 3 adds the intercept, restores the sign and flags saturation.
// ---------------------------------------------------------------------------
module activation_pwl_unit
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic        [1:0]            in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_sat,
    output logic        [CNT_WIDTH-1:0]  sat_cnt,
    input  logic                         sat_clr
);

    if (FRACT_WIDTH < 5 || DATA_WIDTH - FRACT_WIDTH < 4) begin : g_bad_params
        $error("activation_pwl_unit: needs FRACT_WIDTH>=5 and DATA_WIDTH-FRACT_WIDTH>=4");
    end

    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(c_one(FRACT_WIDTH));
    localparam logic [DATA_WIDTH-1:0] TWO      = DATA_WIDTH'(c_two(FRACT_WIDTH));
    localparam logic [DATA_WIDTH-1:0] FIVE     = DATA_WIDTH'(c_five(FRACT_WIDTH));
    localparam logic [DATA_WIDTH-1:0] HALF     = DATA_WIDTH'(c_half(FRACT_WIDTH));
    localparam logic [DATA_WIDTH-1:0] K0P375   = DATA_WIDTH'(c_0p375(FRACT_WIDTH));
    localparam logic [DATA_WIDTH-1:0] K0P625   = DATA_WIDTH'(c_0p625(FRACT_WIDTH));
    localparam logic [DATA_WIDTH-1:0] K2P375   = DATA_WIDTH'(c_2p375(FRACT_WIDTH));
    localparam logic [DATA_WIDTH-1:0] K0P15625 = DATA_WIDTH'(c_0p15625(FRACT_WIDTH));
    localparam logic [DATA_WIDTH-1:0] K0P84375 = DATA_WIDTH'(c_0p84375(FRACT_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    // One global enable: every stage moves together or everything holds
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1 combinational: magnitude (most negative clamps to max) and segment
    act_mode_e             mode_c;
    logic [DATA_WIDTH-1:0] mag_c;
    seg_e                  seg_c;

    assign mode_c = act_mode_e'(in_mode);

    always_comb begin
        mag_c = in_data;
        if (in_data[DATA_WIDTH-1]) begin
            mag_c = (in_data == MOST_NEG) ? MAX_POS : DATA_WIDTH'(-in_data);
        end
    end

    always_comb begin
        seg_c = SEG_0;
        case (mode_c)
            MODE_HTANH: seg_c = (mag_c > ONE) ? SEG_SAT : SEG_0;
            MODE_TANH: begin
                if (mag_c <= K0P375)   seg_c = SEG_0;
                else if (mag_c <= ONE) seg_c = SEG_1;
                else if (mag_c <= TWO) seg_c = SEG_2;
                else                   seg_c = SEG_SAT;
            end
            MODE_SIGM: begin
                if (mag_c < ONE)         seg_c = SEG_0;
                else if (mag_c < K2P375) seg_c = SEG_1;
                else if (mag_c < FIVE)   seg_c = SEG_2;
                else                     seg_c = SEG_SAT;
            end
            default: seg_c = SEG_0;
        endcase
    end

    act_mode_e             s1_mode, s2_mode;
    seg_e                  s1_seg, s2_seg;
    logic                  s1_valid, s2_valid, s1_neg, s2_neg;
    logic [DATA_WIDTH-1:0] s1_mag, s2_slope, slope_c;

    pwl_segment_eval #(.DATA_WIDTH(DATA_WIDTH)) u_seg_eval (
        .mode  (s1_mode),
        .seg   (s1_seg),
        .mag   (s1_mag),
        .slope (slope_c)
    );

    // Stage 3 combinational: intercept, sign restore and saturation flag
    logic [DATA_WIDTH-1:0] icpt_c, sum_c;
    logic [DATA_WIDTH-1:0] result_c;
    logic                  sat_c;

    always_comb begin
        icpt_c = '0;
        case (s2_mode)
            MODE_HTANH: icpt_c = (s2_seg == SEG_SAT) ? ONE : '0;
            MODE_TANH: begin
                case (s2_seg)
                    SEG_1:   icpt_c = K0P15625;
                    SEG_2:   icpt_c = HALF;
                    SEG_SAT: icpt_c = ONE;
                    default: icpt_c = '0;
                endcase
            end
            MODE_SIGM: begin
                case (s2_seg)
                    SEG_0:   icpt_c = HALF;
                    SEG_1:   icpt_c = K0P625;
                    SEG_2:   icpt_c = K0P84375;
                    default: icpt_c = ONE;
                endcase
            end
            default: icpt_c = '0;
        endcase
        sum_c = s2_slope + icpt_c;
        result_c = sum_c;
        if (s2_neg) begin
            case (s2_mode)
                MODE_SIGM: result_c = ONE - sum_c;
                MODE_RELU: result_c = '0;
                default:   result_c = DATA_WIDTH'(-sum_c);
            endcase
        end
        sat_c = (s2_seg == SEG_SAT) && (s2_mode != MODE_RELU);
    end

    // Pipeline registers; bubbles travel as cleared valid bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_mode   <= MODE_HTANH;
            s1_seg    <= SEG_0;
            s1_neg    <= 1'b0;
            s1_mag    <= '0;
            s2_valid  <= 1'b0;
            s2_mode   <= MODE_HTANH;
            s2_seg    <= SEG_0;
            s2_neg    <= 1'b0;
            s2_slope  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_mode   <= mode_c;
            s1_seg    <= seg_c;
            s1_neg    <= in_data[DATA_WIDTH-1];
            s1_mag    <= mag_c;
            s2_valid  <= s1_valid;
            s2_mode   <= s1_mode;
            s2_seg    <= s1_seg;
            s2_neg    <= s1_neg;
            s2_slope  <= slope_c;
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= result_c;
                out_sat  <= sat_c;
            end
        end
    end

    // Saturation counter: clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && out_sat) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_activation_pwl_unit.sv
// ---------------------------------------------------------------------------
// tb_activation_pwl_unit
// Directed self-checking bench. Expected results are hand-computed Q8.8
// values queued in input order and compared by a monitor on output transfers.
// The saturation counter is narrowed to 4 bits so wrap-around is reachable.
// ---------------------------------------------------------------------------
module tb_activation_pwl_unit;

    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_data;
    logic [1:0]      in_mode;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_data;
    logic            out_sat;
    logic [CNTW-1:0] sat_cnt;
    logic            sat_clr;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic [15:0] data;
        logic        sat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct packed {
        logic [1:0]  mode;
        logic [15:0] x;
        logic [15:0] y;
        logic        sat;
    } vec_t;

    localparam int NVEC = 18;
    localparam vec_t VECS [NVEC] = '{
        '{2'b01, 16'h0080, 16'h0074, 1'b0},
        '{2'b01, 16'hFF80, 16'hFF8C, 1'b0},
        '{2'b01, 16'h0300, 16'h0100, 1'b1},
        '{2'b10, 16'h0000, 16'h0080, 1'b0},
        '{2'b10, 16'h0100, 16'h00C0, 1'b0},
        '{2'b10, 16'hFF00, 16'h0040, 1'b0},
        '{2'b10, 16'h0600, 16'h0100, 1'b1},
        '{2'b00, 16'hFD00, 16'hFF00, 1'b1},
        '{2'b11, 16'hFF00, 16'h0000, 1'b0},
        '{2'b11, 16'h0123, 16'h0123, 1'b0},
        '{2'b01, 16'h0060, 16'h0060, 1'b0},
        '{2'b01, 16'h0100, 16'h00C0, 1'b0},
        '{2'b01, 16'h0200, 16'h0100, 1'b0},
        '{2'b10, 16'h0260, 16'h00EB, 1'b0},
        '{2'b10, 16'hFB00, 16'h0000, 1'b1},
        '{2'b00, 16'h0100, 16'h0100, 1'b0},
        '{2'b00, 16'hFF00, 16'hFF00, 1'b0},
        '{2'b11, 16'h8000, 16'h0000, 1'b0}
    };

    activation_pwl_unit #(
        .DATA_WIDTH (16),
        .FRACT_WIDTH(8),
        .CNT_WIDTH  (CNTW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .sat_cnt  (sat_cnt),
        .sat_clr  (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end else begin
            checks_passed++;
        end
    endtask

    // Present one sample, queue its expected result, return one ns after the
    // accepting edge with in_valid still high so calls can run back-to-back
    task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] x,
                                 input logic [15:0] y, input logic sat);
        int guard;
        exp_t e;
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = x;
        e.data = y;
        e.sat  = sat;
        exp_q.push_back(e);
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idleInput();
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drained", exp_q.size(), 32'd0);
    endtask

    task automatic resetDut();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Compare every output transfer against the head of the expected queue
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("out_data", {16'b0, out_data}, {16'b0, mon_e.data});
                checkOutput("out_sat", {31'b0, out_sat}, {31'b0, mon_e.sat});
            end
        end
    end

    initial begin
        in_mode   = 2'b00;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        sat_clr   = 1'b0;
        resetDut();

        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_sat", {31'b0, out_sat}, 32'd0);
        checkOutput("rst_out_data", {16'b0, out_data}, 32'd0);
        checkOutput("rst_sat_cnt", {28'b0, sat_cnt}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Latency: result visible exactly three edges after acceptance
        applyStimulus(2'b01, 16'h0080, 16'h0074, 1'b0);
        idleInput();
        checkOutput("lat_edge1", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("lat_edge2", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("lat_edge3", {31'b0, out_valid}, 32'd1);
        waitDrain();

        // Mixed modes back-to-back
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(VECS[i].mode, VECS[i].x, VECS[i].y, VECS[i].sat);
        end
        idleInput();
        waitDrain();
        checkOutput("sat_after_vectors", {28'b0, sat_cnt}, 32'd4);

        // Clear alone
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        checkOutput("sat_clr_alone", {28'b0, sat_cnt}, 32'd0);

        // Three saturated transfers
        for (int i = 0; i < 3; i++) applyStimulus(2'b01, 16'h0300, 16'h0100, 1'b1);
        idleInput();
        waitDrain();
        checkOutput("sat_cnt_3", {28'b0, sat_cnt}, 32'd3);

        // Clear coincident with a saturated transfer
        out_ready = 1'b0;
        applyStimulus(2'b10, 16'h0600, 16'h0100, 1'b1);
        idleInput();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("held_valid", {31'b0, out_valid}, 32'd1);
        sat_clr   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        checkOutput("sat_clr_prio", {28'b0, sat_cnt}, 32'd0);
        waitDrain();

        // Fill the counter to all-ones, then wrap
        for (int i = 0; i < 15; i++) applyStimulus(2'b00, 16'hFD00, 16'hFF00, 1'b1);
        idleInput();
        waitDrain();
        checkOutput("sat_cnt_full", {28'b0, sat_cnt}, 32'd15);
        applyStimulus(2'b01, 16'h8000, 16'hFF00, 1'b1);
        idleInput();
        waitDrain();
        checkOutput("sat_cnt_wrap", {28'b0, sat_cnt}, 32'd0);

        // Stream 8 samples with a 4-cycle downstream stall mid-stream
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    applyStimulus(2'b11, 16'(i * 17), 16'(i * 17), 1'b0);
                end
                idleInput();
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
                    checkOutput("stall_out_valid", {31'b0, out_valid}, 32'd1);
                    checkOutput("stall_data", {16'b0, out_data},
                                {16'b0, (exp_q.size() != 0) ? exp_q[0].data : 16'hDEAD});
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();

        // Reset with samples in flight
        applyStimulus(2'b10, 16'h0600, 16'h0100, 1'b1);
        idleInput();
        waitDrain();
        checkOutput("sat_cnt_pre_rst", {28'b0, sat_cnt}, 32'd1);
        out_ready = 1'b0;
        applyStimulus(2'b01, 16'h0300, 16'h0100, 1'b1);
        applyStimulus(2'b10, 16'h0100, 16'h00C0, 1'b0);
        applyStimulus(2'b11, 16'h0123, 16'h0123, 1'b0);
        idleInput();
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst_sat_cnt", {28'b0, sat_cnt}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checkOutput("no_stale_out", {31'b0, out_valid}, 32'd0);
        end

        // Most negative input through tanh
        applyStimulus(2'b01, 16'h8000, 16'hFF00, 1'b1);
        idleInput();
        waitDrain();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/activation_pwl_unit.md
ACTIVATION_PWL_UNIT -- requirements
Module: activation_pwl_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed two's-complement width of input and output samples.
REQ-002 SHALL have parameter FRACT_WIDTH, default 8, meaning fractional bits of input and output (same Q format).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning saturation-counter width.
REQ-004 Ports (clock and reset first): clk  input  1  single clock, rising edge; reset_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  input sample valid; in_ready  output  1  unit accepts a sample this cycle.
REQ-006 in_data  input  DATA_WIDTH  signed sample X; in_mode  input  2  function select, travels with the sample.
REQ-007 out_valid  output  1  result valid; out_ready  input  1  downstream accepts; out_data  output  DATA_WIDTH  signed result Y.
REQ-008 out_sat  output  1  result came from a saturated segment; sat_cnt  output  CNT_WIDTH  count of saturated results; sat_clr  input  1  synchronous clear of sat_cnt.

Function
REQ-009 Modes SHALL be: 00 hard-tanh, clamp X to [-1,+1]; 01 tanh PWL; 10 sigmoid PWL; 11 ReLU, max(0,X).
REQ-010 Tanh PWL on A=|X|, result sign-restored: A<=0.375 -> A; 0.375<A<=1 -> (A>>1)+(A>>4)+(A>>5)+0.15625; 1<A<=2 -> (A>>2)+0.5; A>2 -> 1.0 (saturated).
REQ-011 Sigmoid PWL on A=|X|: A<1 -> (A>>2)+0.5; 1<=A<2.375 -> (A>>3)+0.625; 2.375<=A<5 -> (A>>5)+0.84375; A>=5 -> 1.0 (saturated); X<0 -> 1.0 minus that value.
REQ-012 Hard-tanh SHALL flag out_sat when |X|>1; ReLU SHALL never flag out_sat.
REQ-013 All shifts SHALL be logical right shifts of the non-negative magnitude (truncation); constants SHALL be rounded-down Q(FRACT_WIDTH) values.
REQ-014 X equal to the most negative value SHALL be treated as magnitude 2^(DATA_WIDTH-1)-1 (no overflow in |X|).
REQ-015 Parameter legality: FRACT_WIDTH>=5 and DATA_WIDTH-FRACT_WIDTH>=4; otherwise elaboration SHALL fail.
REQ-016 Pipeline SHALL be 3 stages: S1 magnitude/sign/segment select, S2 slope shift-add, S3 intercept add, sign restore, saturation flag; latency exactly 3 cycles when out_ready stays high.
REQ-017 Transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-018 Stall: in_ready = !out_valid || out_ready; when low the whole pipeline SHALL hold all stage registers and per-stage valid bits.
REQ-019 out_data/out_sat SHALL remain stable while out_valid && !out_ready.
REQ-020 Bubbles SHALL propagate as invalid stages; throughput one sample per cycle with out_ready high.
REQ-021 sat_cnt SHALL increment by 1 on each output transfer with out_sat=1, wrap from all-ones to 0; sat_clr has priority over a same-cycle increment (result 0).

Reset
REQ-022 On reset_n low, asynchronously: all stage valid bits, out_valid, out_sat 0; out_data 0; sat_cnt 0; in_ready 1 after reset deasserts.
REQ-023 Reset mid-operation SHALL discard all in-flight samples; no partial result emerges after reset release.

Structure
REQ-024 Shared package activation_pkg SHALL hold the mode encodings and segment-boundary/intercept constants expressed as functions of FRACT_WIDTH.
REQ-025 One sub-module, pwl_segment_eval (combinational slope shift-add per mode/segment), SHALL be instantiated in S2; remaining logic is flat.

Verification
REQ-026 Mode 01, X=0x0080 -> Y=0x0074 after 3 cycles; X=0xFF80 -> Y=0xFF8C; X=0x0300 -> Y=0x0100, out_sat=1.
REQ-027 Mode 10, X=0x0000 -> 0x0080; X=0x0100 -> 0x00C0; X=0xFF00 -> 0x0040; X=0x0600 -> 0x0100, out_sat=1.
REQ-028 Mode 00 X=0xFD00 -> 0xFF00, out_sat=1; mode 11 X=0xFF00 -> 0x0000, X=0x0123 -> 0x0123; mixed modes back-to-back, results in order.
REQ-029 Stream 8 samples, hold out_ready low 4 cycles mid-stream -> in_ready low, out_data stable, no loss/duplication, order preserved.
REQ-030 sat_cnt: 3 saturated transfers -> 3; sat_clr coincident with saturated transfer -> 0; preload to all-ones then one saturated transfer -> 0.
REQ-031 Assert reset_n low with 3 samples in flight -> out_valid 0 immediately, sat_cnt 0, no stale output after release; X=0x8000 mode 01 -> 0xFF00.
